reg_dump_unit: RTL and testbench

REG_DUMP_UNIT -- requirements
Module: reg_dump_unit

---
 rtl/reg_dump_unit.sv | 145 ++++++++++++++
 tb/tb_reg_dump_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_unit.sv
// reg_dump_unit
//   Walks an inclusive range of a 32 x 32 register file through its
//   asynchronous read port. Each register goes out as one valid/ready beat.
//   A running XOR checksum covers every beat the consumer accepts.
//
// Ports
//   clk, reset              clock; synchronous active-high reset
//   start, abort            begin a dump (sampled in IDLE) / cancel a dump
//   first_idx, last_idx     inclusive range, latched together with start
//   rf_addr, rf_data        registered read address out, read data back
//   dump_valid/ready        output beat handshake
//   dump_idx/data/last      contents of the current beat
//   busy, done              dump in progress / one-cycle completion pulse
//   checksum                XOR of the beats accepted in the current or last dump
module reg_dump_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   input  logic [4:0]  first_idx,
   input  logic [4:0]  last_idx,
   output logic [4:0]  rf_addr,
   input  logic [31:0] rf_data,
   output logic        dump_valid,
   input  logic        dump_ready,
   output logic [4:0]  dump_idx,
   output logic [31:0] dump_data,
   output logic        dump_last,
   output logic        busy,
   output logic        done,
   output logic [31:0] checksum
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_SEND  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [4:0]  cur_q, cur_d;
   logic [4:0]  last_q, last_d;
   logic [4:0]  rf_addr_q, rf_addr_d;
   logic        dump_valid_q, dump_valid_d;
   logic [4:0]  dump_idx_q, dump_idx_d;
   logic [31:0] dump_data_q, dump_data_d;
   logic        dump_last_q, dump_last_d;
   logic [31:0] checksum_q, checksum_d;

   always_comb begin
      state_d      = state_q;
      cur_d        = cur_q;
      last_d       = last_q;
      rf_addr_d    = rf_addr_q;
      dump_valid_d = dump_valid_q;
      dump_idx_d   = dump_idx_q;
      dump_data_d  = dump_data_q;
      dump_last_d  = dump_last_q;
      checksum_d   = checksum_q;

      case (state_q)
         S_IDLE: begin
            // abort beats start when both are high in IDLE
            if (start && !abort) begin
               checksum_d = '0;
               if (first_idx <= last_idx) begin
                  cur_d     = first_idx;
                  last_d    = last_idx;
                  rf_addr_d = first_idx;
                  state_d   = S_FETCH;
               end else begin
                  // Empty range: finish without emitting any beat
                  state_d = S_DONE;
               end
            end
         end
         S_FETCH: begin
            // Snapshot the register now so later writes cannot change the beat
            dump_data_d  = rf_data;
            dump_idx_d   = cur_q;
            dump_last_d  = (cur_q == last_q);
            dump_valid_d = 1'b1;
            state_d      = S_SEND;
         end
         S_SEND: begin
            if (dump_valid_q && dump_ready) begin
               checksum_d   = checksum_q ^ dump_data_q;
               dump_valid_d = 1'b0;
               if (cur_q == last_q) begin
                  state_d = S_DONE;
               end else begin
                  // cur < last <= 31 here, so the increment cannot wrap
                  cur_d     = cur_q + 5'd1;
                  rf_addr_d = cur_q + 5'd1;
                  state_d   = S_FETCH;
               end
            end
         end
         default: state_d = S_IDLE;  // S_DONE lasts exactly one cycle
      endcase

      // abort overrides any handshake in the same cycle: the beat is dropped
      // and the checksum keeps its partial value
      if (abort && (state_q != S_IDLE)) begin
         state_d      = S_IDLE;
         dump_valid_d = 1'b0;
         checksum_d   = checksum_q;
         cur_d        = cur_q;
         rf_addr_d    = rf_addr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cur_q        <= '0;
         last_q       <= '0;
         rf_addr_q    <= '0;
         dump_valid_q <= 1'b0;
         dump_idx_q   <= '0;
         dump_data_q  <= '0;
         dump_last_q  <= 1'b0;
         checksum_q   <= '0;
      end else begin
         state_q      <= state_d;
         cur_q        <= cur_d;
         last_q       <= last_d;
         rf_addr_q    <= rf_addr_d;
         dump_valid_q <= dump_valid_d;
         dump_idx_q   <= dump_idx_d;
         dump_data_q  <= dump_data_d;
         dump_last_q  <= dump_last_d;
         checksum_q   <= checksum_d;
      end
   end

   assign rf_addr    = rf_addr_q;
   assign dump_valid = dump_valid_q;
   assign dump_idx   = dump_idx_q;
   assign dump_data  = dump_data_q;
   assign dump_last  = dump_last_q;
   assign checksum   = checksum_q;
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_reg_dump_unit.sv
// tb_reg_dump_unit
//   Directed bench for reg_dump_unit. A behavioural register file answers
//   rf_addr asynchronously. exp[] holds the value each beat must report.
//   Inputs are driven and outputs sampled on the falling edge.
module tb_reg_dump_unit;

   logic        clk = 1'b0;
   logic        reset, start, abort, dump_ready;
   logic [4:0]  first_idx, last_idx, rf_addr, dump_idx;
   logic [31:0] rf_data, dump_data, checksum;
   logic        dump_valid, dump_last, busy, done;

   logic [31:0] rf  [32];
   logic [31:0] exp [32];

   int n_chk = 0;
   int n_fail = 0;

   int          beats, fc, hc, dc, nb;
   logic [31:0] ck;
   bit          hit;

   always #5 clk = ~clk;

   assign rf_data = rf[rf_addr];

   reg_dump_unit dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .first_idx(first_idx), .last_idx(last_idx),
      .rf_addr(rf_addr), .rf_data(rf_data),
      .dump_valid(dump_valid), .dump_ready(dump_ready),
      .dump_idx(dump_idx), .dump_data(dump_data), .dump_last(dump_last),
      .busy(busy), .done(done), .checksum(checksum)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rf_addr"}, {27'd0, rf_addr}, 32'd0);
      check({tag, "_valid"},   {31'd0, dump_valid}, 32'd0);
      check({tag, "_idx"},     {27'd0, dump_idx}, 32'd0);
      check({tag, "_data"},    dump_data, 32'd0);
      check({tag, "_last"},    {31'd0, dump_last}, 32'd0);
      check({tag, "_busy"},    {31'd0, busy}, 32'd0);
      check({tag, "_done"},    {31'd0, done}, 32'd0);
      check({tag, "_cksum"},   checksum, 32'd0);
   endtask

   // Runs one dump of f..l. Each beat is stalled for `stall` cycles before it
   // is accepted. With wr_en the register of a pending beat is overwritten
   // while the beat sits in SEND. Returns the cycle of the first valid beat,
   // of the last acceptance and of done, counted from the cycle after start.
   task automatic do_dump(input logic [4:0] f, input logic [4:0] l, input int stall,
                          input bit wr_en, input logic [31:0] wr_val,
                          output int nbeats, output logic [31:0] cks,
                          output int first_cyc, output int hs_cyc, output int done_cyc);
      int          sc;
      logic [4:0]  ei;
      logic [4:0]  c_idx;
      logic [31:0] c_data;
      logic        c_last;
      @(negedge clk);
      start = 1'b1; first_idx = f; last_idx = l;
      @(negedge clk);
      start = 1'b0;
      nbeats = 0; cks = '0; first_cyc = -1; hs_cyc = -1; done_cyc = -1; sc = 0;
      c_idx = '0; c_data = '0; c_last = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (done) begin
            done_cyc = cyc;
            break;
         end
         if (dump_valid) begin
            ei = f + nbeats[4:0];
            if (first_cyc < 0) first_cyc = cyc;
            if (sc == 0) begin
               c_idx = dump_idx; c_data = dump_data; c_last = dump_last;
               check("beat_idx",  {27'd0, dump_idx}, {27'd0, ei});
               check("beat_data", dump_data, exp[ei]);
               check("beat_last", {31'd0, dump_last}, {31'd0, (ei == l)});
               if (wr_en) rf[ei] = wr_val;
            end else begin
               check("hold_idx",  {27'd0, dump_idx}, {27'd0, c_idx});
               check("hold_data", dump_data, c_data);
               check("hold_last", {31'd0, dump_last}, {31'd0, c_last});
            end
            if (sc < stall) begin
               dump_ready = 1'b0;
               sc++;
            end else begin
               dump_ready = 1'b1;
               cks ^= exp[ei];
               nbeats++;
               sc = 0;
               hs_cyc = cyc;
            end
         end else begin
            dump_ready = 1'b0;
         end
         @(negedge clk);
      end
      dump_ready = 1'b0;
      if (done_cyc < 0) check("done_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 32; i++) begin
         rf[i] = '0;
         exp[i] = '0;
      end
      reset = 1'b1; start = 1'b0; abort = 1'b0; dump_ready = 1'b0;
      first_idx = '0; last_idx = '0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b0;

      // Full range 0..31 with only x2 nonzero, consumer always ready
      rf[2] = 32'h0000_2ffc; exp[2] = 32'h0000_2ffc;
      do_dump(5'd0, 5'd31, 0, 1'b0, 32'd0, beats, ck, fc, hc, dc);
      check("full_beats", beats, 32);
      check("full_first_lat", fc, 1);
      check("full_done_lat", dc, hc + 1);
      check("full_cksum", checksum, 32'h0000_2ffc);
      check("full_cksum_model", checksum, ck);
      @(negedge clk);
      check("full_done_pulse", {31'd0, done}, 32'd0);
      check("full_busy_after", {31'd0, busy}, 32'd0);
      check("full_cksum_hold", checksum, 32'h0000_2ffc);

      // Range 5..7, every beat stalled three cycles
      rf[5] = 32'h11; exp[5] = 32'h11;
      rf[6] = 32'h22; exp[6] = 32'h22;
      rf[7] = 32'h44; exp[7] = 32'h44;
      do_dump(5'd5, 5'd7, 3, 1'b0, 32'd0, beats, ck, fc, hc, dc);
      check("stall_beats", beats, 3);
      check("stall_cksum", checksum, 32'h77);

      // Reversed range: no beats, done right away, checksum cleared
      do_dump(5'd9, 5'd3, 0, 1'b0, 32'd0, beats, ck, fc, hc, dc);
      check("empty_beats", beats, 0);
      check("empty_no_valid", fc, -1);
      check("empty_done_lat", dc, 0);
      check("empty_cksum", checksum, 32'd0);
      @(negedge clk);
      check("empty_busy_after", {31'd0, busy}, 32'd0);

      // Register write while beat x6 is pending must not alter that beat
      do_dump(5'd6, 5'd6, 2, 1'b1, 32'hdead_beef, beats, ck, fc, hc, dc);
      check("snap_beats", beats, 1);
      check("snap_cksum_old", checksum, 32'h22);
      exp[6] = 32'hdead_beef;
      do_dump(5'd6, 5'd6, 0, 1'b0, 32'd0, beats, ck, fc, hc, dc);
      check("snap_cksum_new", checksum, 32'hdead_beef);

      // Abort during beat 4 with ready high; a start on beat 1 is ignored
      @(negedge clk);
      start = 1'b1; first_idx = 5'd0; last_idx = 5'd31;
      @(negedge clk);
      start = 1'b0; nb = 0; hit = 1'b0;
      for (int cyc = 0; cyc < 200; cyc++) begin
         if (dump_valid) begin
            check("abort_seq_idx", {27'd0, dump_idx}, nb);
            dump_ready = 1'b1;
            if (dump_idx == 5'd4) begin
               abort = 1'b1;
               hit = 1'b1;
               break;
            end
            if (dump_idx == 5'd1) begin
               start = 1'b1; first_idx = 5'd20; last_idx = 5'd25;
            end
            nb++;
         end else begin
            dump_ready = 1'b0;
            start = 1'b0;
         end
         @(negedge clk);
      end
      if (!hit) check("abort_timeout", 32'd0, 32'd1);
      @(negedge clk);
      abort = 1'b0; dump_ready = 1'b0; start = 1'b0;
      check("abort_valid", {31'd0, dump_valid}, 32'd0);
      check("abort_done",  {31'd0, done}, 32'd0);
      check("abort_busy",  {31'd0, busy}, 32'd0);
      check("abort_cksum", checksum, 32'h0000_2ffc);
      @(negedge clk);
      check("abort_stays_idle", {31'd0, busy}, 32'd0);

      // start and abort together in IDLE: stay idle, checksum not cleared
      start = 1'b1; abort = 1'b1; first_idx = 5'd0; last_idx = 5'd3;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check("idle_abort_busy", {31'd0, busy}, 32'd0);
      check("idle_abort_cksum", checksum, 32'h0000_2ffc);

      // Reset in the middle of a dump while beat 10 is pending
      @(negedge clk);
      start = 1'b1; first_idx = 5'd0; last_idx = 5'd31;
      @(negedge clk);
      start = 1'b0; hit = 1'b0;
      for (int cyc = 0; cyc < 200; cyc++) begin
         if (dump_valid) begin
            dump_ready = 1'b1;
            if (dump_idx == 5'd10) begin
               reset = 1'b1;
               hit = 1'b1;
               break;
            end
         end else begin
            dump_ready = 1'b0;
         end
         @(negedge clk);
      end
      if (!hit) check("reset_mid_timeout", 32'd0, 32'd1);
      @(negedge clk);
      reset = 1'b0; dump_ready = 1'b0;
      check_all_zero("reset_mid");
      do_dump(5'd0, 5'd1, 0, 1'b0, 32'd0, beats, ck, fc, hc, dc);
      check("post_reset_beats", beats, 2);
      check("post_reset_cksum", checksum, ck);
      @(negedge clk);
      check("post_reset_busy", {31'd0, busy}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
